// File: rtl/lsu_byte_sequencer.sv
// Load/store sequencer: splits a b/h/w request into big-endian byte
// transfers on a handshaked byte port and rebuilds/extends load data.
//
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   LSUValid/Ready   core request handshake (Ready = idle)
//   LSUWr, LSUCtrl   store flag and DMCtrl size/sign code
//   LSUAddress       base byte address
//   LSUDataWr        store data
//   LSUDone/Err      one-cycle completion pulse, illegal-request flag
//   LSUDataRd        extended load result, held until next load
//   MemReq/We/Addr   byte transfer request towards memory
//   MemWData         store byte
//   MemAck/RData     transfer complete, load byte
module lsu_byte_sequencer #(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LSUValid,
   output logic              LSUReady,
   input  logic              LSUWr,
   input  logic [2:0]        LSUCtrl,
   input  logic [ADDR_W-1:0] LSUAddress,
   input  logic [31:0]       LSUDataWr,
   output logic              LSUDone,
   output logic              LSUErr,
   output logic [31:0]       LSUDataRd,
   output logic              MemReq,
   output logic              MemWe,
   output logic [ADDR_W-1:0] MemAddr,
   output logic [7:0]        MemWData,
   input  logic              MemAck,
   input  logic [7:0]        MemRData
);

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      DONE
   } state_t;

   state_t      state;
   logic        wr_q;
   logic        err_q;
   logic [2:0]  ctrl_q;
   logic [2:0]  n_q;
   logic [2:0]  cnt_q;
   logic [31:0] wsh_q;
   logic [31:0] acc_q;

   logic        legal;
   logic [2:0]  n;
   logic [1:0]  fo;
   logic [31:0] wsh;
   logic        last;
   logic [31:0] ext;

   assign LSUReady = (state == IDLE);

   // Size decode and legality of the incoming request.
   always_comb begin
      legal = 1'b0;
      n     = 3'd1;
      fo    = 2'd3;
      unique case (1'b1)
         (LSUCtrl[1:0] == 2'b10): begin
            n  = 3'd4;
            fo = 2'd0;
         end
         (LSUCtrl[1:0] == 2'b01): begin
            n  = 3'd2;
            fo = 2'd2;
         end
         default: begin
            n  = 3'd1;
            fo = 2'd3;
         end
      endcase
      if (LSUWr)
         legal = (LSUCtrl == 3'b000) ||
                 (LSUCtrl == 3'b001) ||
                 (LSUCtrl == 3'b010);
      else
         legal = (LSUCtrl == 3'b000) ||
                 (LSUCtrl == 3'b001) ||
                 (LSUCtrl == 3'b010) ||
                 (LSUCtrl == 3'b100) ||
                 (LSUCtrl == 3'b101);
   end

   // Left-align store data so the first byte sent is always [31:24].
   assign wsh  = LSUDataWr << {fo, 3'b000};
   assign last = (cnt_q == (n_q - 3'd1));

   always_comb begin
      ext = acc_q;
      unique case (ctrl_q)
         3'b000:  ext = {{24{acc_q[7]}}, acc_q[7:0]};
         3'b100:  ext = {24'd0, acc_q[7:0]};
         3'b001:  ext = {{16{acc_q[15]}}, acc_q[15:0]};
         3'b101:  ext = {16'd0, acc_q[15:0]};
         default: ext = acc_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wr_q      <= 1'b0;
         err_q     <= 1'b0;
         ctrl_q    <= 3'd0;
         n_q       <= 3'd1;
         cnt_q     <= 3'd0;
         wsh_q     <= 32'd0;
         acc_q     <= 32'd0;
         LSUDone   <= 1'b0;
         LSUErr    <= 1'b0;
         LSUDataRd <= 32'd0;
         MemReq    <= 1'b0;
         MemWe     <= 1'b0;
         MemAddr   <= '0;
         MemWData  <= 8'd0;
      end else begin
         LSUDone <= 1'b0;
         LSUErr  <= 1'b0;
         unique case (state)
            IDLE: begin
               if (LSUValid) begin
                  wr_q   <= LSUWr;
                  ctrl_q <= LSUCtrl;
                  n_q    <= n;
                  cnt_q  <= 3'd0;
                  err_q  <= !legal;
                  if (legal) begin
                     state    <= ACCESS;
                     MemReq   <= 1'b1;
                     MemWe    <= LSUWr;
                     MemAddr  <= LSUAddress + ADDR_W'(fo);
                     MemWData <= wsh[31:24];
                     wsh_q    <= wsh << 8;
                  end else begin
                     state <= DONE;
                  end
               end
            end
            ACCESS: begin
               if (MemReq && MemAck) begin
                  acc_q <= {acc_q[23:0], MemRData};
                  cnt_q <= cnt_q + 3'd1;
                  if (last) begin
                     MemReq <= 1'b0;
                     MemWe  <= 1'b0;
                     state  <= DONE;
                  end else begin
                     MemAddr  <= MemAddr + ADDR_W'(1);
                     MemWData <= wsh_q[31:24];
                     wsh_q    <= wsh_q << 8;
                  end
               end
            end
            DONE: begin
               LSUDone <= 1'b1;
               LSUErr  <= err_q;
               if (!err_q && !wr_q)
                  LSUDataRd <= ext;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Directed bench for lsu_byte_sequencer with a byte memory model
// and scoreboards for transfers and completions.
module tb_lsu_byte_sequencer;

   logic        clk = 1'b0;
   logic        rst;
   logic        LSUValid;
   logic        LSUReady;
   logic        LSUWr;
   logic [2:0]  LSUCtrl;
   logic [31:0] LSUAddress;
   logic [31:0] LSUDataWr;
   logic        LSUDone;
   logic        LSUErr;
   logic [31:0] LSUDataRd;
   logic        MemReq;
   logic        MemWe;
   logic [31:0] MemAddr;
   logic [7:0]  MemWData;
   logic        MemAck;
   logic [7:0]  MemRData;

   always #5 clk = ~clk;

   lsu_byte_sequencer #(.ADDR_W(32)) dut (
      .clk        (clk),
      .rst        (rst),
      .LSUValid   (LSUValid),
      .LSUReady   (LSUReady),
      .LSUWr      (LSUWr),
      .LSUCtrl    (LSUCtrl),
      .LSUAddress (LSUAddress),
      .LSUDataWr  (LSUDataWr),
      .LSUDone    (LSUDone),
      .LSUErr     (LSUErr),
      .LSUDataRd  (LSUDataRd),
      .MemReq     (MemReq),
      .MemWe      (MemWe),
      .MemAddr    (MemAddr),
      .MemWData   (MemWData),
      .MemAck     (MemAck),
      .MemRData   (MemRData)
   );

   typedef struct packed {
      logic [31:0] a;
      logic        we;
      logic [7:0]  d;
   } xfer_t;

   typedef struct packed {
      logic        err;
      logic [31:0] d;
   } done_t;

   xfer_t xq[$];
   done_t dq[$];
   xfer_t ex;
   done_t ed;

   int ncmp = 0;
   int nerr = 0;
   int cyc = 0;
   int dcnt = 0;
   int dcyc = 0;
   int acks = 0;
   int hcnt = 0;
   int waits = 0;
   int wcnt = 0;
   int d0;
   logic [7:0] mem [256];

   task automatic chk(input string tag,
                      input logic [31:0] got,
                      input logic [31:0] exp);
      ncmp++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Byte memory with a fixed number of wait states per transfer.
   assign MemAck   = MemReq && (wcnt == waits);
   assign MemRData = mem[MemAddr[7:0]];

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!MemReq || MemAck) wcnt <= 0;
      else wcnt <= wcnt + 1;
      if (MemReq && MemAck && MemWe)
         mem[MemAddr[7:0]] = MemWData;
   end

   // Transfer and completion monitors.
   always @(negedge clk) begin
      if (rst) begin
         hcnt = 0;
      end else if (MemReq) begin
         hcnt = hcnt + 1;
         if (MemAck) begin
            acks = acks + 1;
            chk("xfer_expected", 32'(xq.size() != 0), 32'd1);
            if (xq.size() != 0) begin
               ex = xq.pop_front();
               chk("xfer_addr", MemAddr, ex.a);
               chk("xfer_we", 32'(MemWe), 32'(ex.we));
               if (ex.we)
                  chk("xfer_wdata", 32'(MemWData), 32'(ex.d));
               chk("xfer_hold", 32'(hcnt), 32'(waits + 1));
            end
            hcnt = 0;
         end
      end
      if (!rst && LSUDone) begin
         dcnt = dcnt + 1;
         dcyc = cyc;
         chk("done_expected", 32'(dq.size() != 0), 32'd1);
         if (dq.size() != 0) begin
            ed = dq.pop_front();
            chk("done_err", 32'(LSUErr), 32'(ed.err));
            chk("done_data", LSUDataRd, ed.d);
         end
      end
   end

   task automatic req(input logic wr,
                      input logic [2:0] ctrl,
                      input logic [31:0] addr,
                      input logic [31:0] wd,
                      input logic xerr,
                      input logic [31:0] xdata,
                      input int xlat,
                      input bit hold,
                      input string tag);
      int n;
      int fo;
      int acc;
      int dc;
      logic [31:0] sh;
      if (!xerr) begin
         case (ctrl[1:0])
            2'b00:   begin n = 1; fo = 3; end
            2'b01:   begin n = 2; fo = 2; end
            default: begin n = 4; fo = 0; end
         endcase
         sh = wd << (8 * fo);
         for (int k = 0; k < n; k++) begin
            xq.push_back({addr + 32'(fo + k), wr, sh[31:24]});
            sh = sh << 8;
         end
      end
      dq.push_back({xerr, xdata});
      @(negedge clk);
      for (int i = 0; i < 50 && !LSUReady; i++) @(negedge clk);
      LSUWr      = wr;
      LSUCtrl    = ctrl;
      LSUAddress = addr;
      LSUDataWr  = wd;
      LSUValid   = 1'b1;
      dc = dcnt;
      @(posedge clk);
      #1;
      acc = cyc;
      if (hold) begin
         LSUAddress = 32'h10;
         chk({tag, "_busy_ready"}, 32'(LSUReady), 32'd0);
      end else begin
         LSUValid = 1'b0;
      end
      for (int i = 0; i < 200 && dcnt == dc; i++) begin
         @(negedge clk);
         #1;
      end
      LSUValid = 1'b0;
      chk({tag, "_done_seen"}, 32'(dcnt != dc), 32'd1);
      chk({tag, "_latency"}, 32'(dcyc - acc), 32'(xlat));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
      mem[8'h10] = 8'h80;
      mem[8'h11] = 8'h12;
      mem[8'h12] = 8'hF3;
      mem[8'h13] = 8'h45;
      rst        = 1'b1;
      LSUValid   = 1'b0;
      LSUWr      = 1'b0;
      LSUCtrl    = 3'b000;
      LSUAddress = 32'd0;
      LSUDataWr  = 32'd0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_ready", 32'(LSUReady), 32'd1);
      chk("rst_flags", {28'd0, LSUDone, LSUErr, MemReq, MemWe}, 32'd0);
      chk("rst_datard", LSUDataRd, 32'd0);
      chk("rst_memaddr", MemAddr, 32'd0);
      chk("rst_wdata", 32'(MemWData), 32'd0);
      rst = 1'b0;

      req(0, 3'b010, 32'h10, 32'h0, 0, 32'h8012F345, 5, 0, "lw");
      req(0, 3'b001, 32'h10, 32'h0, 0, 32'hFFFFF345, 3, 0, "lh");
      req(0, 3'b101, 32'h10, 32'h0, 0, 32'h0000F345, 3, 0, "lhu");
      req(0, 3'b000, 32'h0F, 32'h0, 0, 32'hFFFFFFF3, 2, 0, "lb");
      req(0, 3'b100, 32'h0F, 32'h0, 0, 32'h000000F3, 2, 0, "lbu");

      waits = 2;
      req(1, 3'b010, 32'h20, 32'hDEADBEEF, 0, 32'h000000F3, 13, 0, "sw");
      chk("sw_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]},
          32'hDEADBEEF);
      req(1, 3'b001, 32'h20, 32'h00001234, 0, 32'h000000F3, 7, 0, "sh");
      chk("sh_mem", {mem[8'h20], mem[8'h21], mem[8'h22], mem[8'h23]},
          32'hDEAD1234);
      waits = 0;

      req(0, 3'b011, 32'h10, 32'h0, 1, 32'h000000F3, 1, 0, "ld_illegal");
      req(1, 3'b100, 32'h10, 32'h5A, 1, 32'h000000F3, 1, 0, "st_illegal");

      // Reset after the second acknowledged byte of a word load.
      xq.push_back({32'h10, 1'b0, 8'h00});
      xq.push_back({32'h11, 1'b0, 8'h00});
      acks = 0;
      d0 = dcnt;
      @(negedge clk);
      LSUWr      = 1'b0;
      LSUCtrl    = 3'b010;
      LSUAddress = 32'h10;
      LSUValid   = 1'b1;
      @(posedge clk);
      #1;
      LSUValid = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_mid_acks", 32'(acks), 32'd2);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("rst_mid_memreq", 32'(MemReq), 32'd0);
      chk("rst_mid_ready", 32'(LSUReady), 32'd1);
      chk("rst_mid_datard", LSUDataRd, 32'd0);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("rst_mid_nodone", 32'(dcnt - d0), 32'd0);
      chk("rst_mid_noxfer", 32'(xq.size()), 32'd0);
      req(0, 3'b000, 32'h0F, 32'h0, 0, 32'hFFFFFFF3, 2, 0, "lb_after_rst");

      mem[8'hFE] = 8'h11;
      mem[8'hFF] = 8'h22;
      mem[8'h00] = 8'h33;
      mem[8'h01] = 8'h44;
      req(0, 3'b010, 32'hFFFFFFFE, 32'h0, 0, 32'h11223344, 5, 1, "lw_wrap");
      repeat (4) @(negedge clk);
      #1;
      chk("end_xq_empty", 32'(xq.size()), 32'd0);
      chk("end_dq_empty", 32'(dq.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule

// File: doc/lsu_byte_sequencer.md
Name: lsu_byte_sequencer

Overview:
- Load/store initiator between the single-cycle core's memory stage and a byte-wide, handshaked data-memory port.
- Accepts one word, halfword or byte request using the core's DMCtrl encoding.
- Serializes the request into byte transfers in big-endian order.
- For loads, reassembles the returned bytes and sign- or zero-extends the result.
- Replaces direct combinational access to the data memory once that memory becomes multi-cycle.

Parameters:
- ADDR_W, 32, width of the core address and the memory byte address.

Ports:
- clk  input  1  clock, all state changes on the rising edge
- rst  input  1  reset, synchronous, active-high
- LSUValid  input  1  request valid from the core
- LSUReady  output  1  block idle and able to accept a request
- LSUWr  input  1  1 = store, 0 = load
- LSUCtrl  input  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- LSUAddress  input  ADDR_W  base byte address
- LSUDataWr  input  32  store data
- LSUDone  output  1  one-cycle completion pulse
- LSUErr  output  1  illegal request; valid only while LSUDone is high
- LSUDataRd  output  32  extended load result
- MemReq  output  1  byte transfer request
- MemWe  output  1  byte write enable
- MemAddr  output  ADDR_W  byte address
- MemWData  output  8  write byte
- MemAck  input  1  transfer complete; may be high in the same cycle as MemReq
- MemRData  input  8  read byte, valid when MemAck is high

Behaviour:
- Reset values:
  - State IDLE, LSUReady=1.
  - LSUDone, LSUErr, MemReq and MemWe = 0.
  - LSUDataRd, MemAddr and MemWData = 0.
- Accept: at a rising edge with LSUValid && LSUReady, capture LSUWr, LSUCtrl, LSUAddress and LSUDataWr. Port changes after capture are ignored.
- LSUReady = (state == IDLE). There is no queueing; LSUValid while busy is ignored.
- Byte count N and first offset:
  - b/bu: N=1, first offset 3.
  - h/hu: N=2, first offset 2.
  - w: N=4, first offset 0.
  - The k-th transfer addresses LSUAddress + first offset + k, modulo 2^ADDR_W (wraps).
- Legality:
  - Loads accept ctrl 000, 001, 010, 100, 101.
  - Stores accept ctrl 000, 001, 010.
  - Any other request goes IDLE→DONE with LSUErr=1, no MemReq, and LSUDataRd unchanged.
- FSM:
  - IDLE→ACCESS on a legal accept.
  - ACCESS: MemReq=1, MemWe=captured LSUWr, with MemAddr and MemWData held stable until MemAck.
  - On MemReq && MemAck: the byte counter increments. If the count reaches N, go to DONE. Otherwise drive the next address and data in the following cycle; MemReq stays high (back-to-back allowed).
  - DONE: LSUDone=1 for exactly one cycle, MemReq=0, then IDLE.
- Store data: the byte at offset o (0..3) is LSUDataWr[(3-o)*8 +: 8].
  - Word: bytes [31:24] first.
  - Halfword: [15:8] to offset 2, then [7:0] to offset 3.
  - Byte: [7:0] to offset 3.
- Load assembly:
  - Shift register; each ack does acc = {acc[23:0], MemRData}.
  - In DONE, LSUDataRd = w: acc; h: sign-extend acc[15:0]; hu: zero-extend; b: sign-extend acc[7:0]; bu: zero-extend.
  - LSUDataRd holds until the next completed load. Stores do not change it.
- Latency: with zero-wait memory, LSUDone rises N+1 cycles after the accept edge. Each memory wait cycle adds one.
- Reset mid-operation: the next edge forces IDLE, MemReq=0, no LSUDone, and all outputs to their reset values. The memory must tolerate a withdrawn MemReq.
- MemAck while MemReq=0 is ignored.

Test Plan:
- Memory 0x10..0x13 = 80,12,F3,45, zero wait; lw 0x10 → MemAddr 10,11,12,13 on consecutive cycles; LSUDone 5 cycles after accept; LSUDataRd=0x8012F345.
- lh 0x10 → addresses 12,13, result 0xFFFFF345; lhu → 0x0000F345; lb 0x0F → address 12, result 0xFFFFFFF3; lbu 0x0F → 0x000000F3.
- Two-wait-state memory, sw 0x20 data 0xDEADBEEF → writes DE,AD,BE,EF to 20..23, each MemReq held 3 cycles; LSUDone 13 cycles after accept; then sh 0x20 data 0x00001234 → 0x22=12, 0x23=34 only.
- Load ctrl 011, and store ctrl 100 → no MemReq; LSUDone and LSUErr high 1 cycle after accept; LSUDataRd unchanged.
- rst asserted after the 2nd ack of a lw → MemReq low after that edge, no LSUDone, LSUReady=1; a following lb completes normally.
- lw at 0xFFFFFFFE → addresses FFFFFFFE, FFFFFFFF, 0, 1; LSUValid held high with LSUAddress changed while busy → no second accept until IDLE.
